usb_link_ctrl: RTL and testbench
================================

# usb_link_ctrl

Sequences the USB device link layer beside `usb_device_controller`: owns the soft-connect pull-up (`GPIO_1[26]`), watches the D+/D- line state, and classifies bus events (attach, bus reset, suspend, resume). It replaces the hard-wired `~reset` pull-up drive. It gives the SIE and the j1 I/O map a clean link state plus one-cycle event strobes. Runs in the USB clock domain (`clk`, 48 MHz full speed).

## Interface
- `T_DETACH_CYC`, 480000: minimum pull-up-off time after disconnect (10 ms).
- `T_RESET_CYC`, 120: continuous SE0 length classified as bus reset (2.5 µs).
- `T_SUSPEND_CYC`, 144000: continuous J (idle) length classified as suspend (3 ms).
- `T_DEBOUNCE_CYC`, 4: line-state stability filter length.
- `CNT_W`, 20: timer width. Must satisfy `2**CNT_W > max(T_*)`.
- `clk` in 1: USB clock.
- `reset` in 1: synchronous, active-high.
- `d_i` in `d_port_t`: raw `{D+, D-}` from pins; asynchronous.
- `d_en` in 1: SIE transmit enable. While high, line monitoring is frozen.
- `connect_req` in 1: level from CPU register. 1 = present on bus.
- `pullup_en` out 1: drives the 1.5 kΩ pull-up pin.
- `bus_reset` out 1: high while in `LINK_RESET`.
- `suspended` out 1: high while in `LINK_SUSPEND`.
- `ev_reset`, `ev_suspend`, `ev_resume` out 1 each: one-cycle strobes on state entry.
- `line_state` out `line_state_t`: filtered `SE0`/`J`/`K`/`SE1`.
- `link_state` out `link_state_t`: current FSM state.

## Operation
- Line decode from synchronized `d_i`:
  - SE0 = 00; SE1 = 11.
  - J = D+ high for `USB_FULL_SPEED`, D- high otherwise; K is the opposite.
- Filtered `line_state` changes only after the raw decode has been stable for `T_DEBOUNCE_CYC` cycles.
- A single timer counts cycles of an unchanged filtered `line_state`. It clears on any change, and is held at 0 while `d_en`=1 or in `LINK_DETACHED`. It saturates at all-ones and never wraps.
- FSM:
  - `LINK_DETACHED`:
    - `pullup_en`=0; the timer counts cycles here instead.
    - → `LINK_ATTACHED` when timer ≥ `T_DETACH_CYC` and `connect_req`=1.
  - `LINK_ATTACHED`: `pullup_en`=1; waits for host.
    - SE0 timer ≥ `T_RESET_CYC` → `LINK_RESET`.
  - `LINK_RESET`: `bus_reset`=1.
    - Filtered line leaves SE0 → `LINK_ACTIVE`.
  - `LINK_ACTIVE`:
    - SE0 ≥ `T_RESET_CYC` → `LINK_RESET`.
    - J ≥ `T_SUSPEND_CYC` → `LINK_SUSPEND`.
  - `LINK_SUSPEND`: `suspended`=1.
    - Filtered K → `LINK_RESUME`.
    - SE0 ≥ `T_RESET_CYC` → `LINK_RESET`.
  - `LINK_RESUME`:
    - Line returns to J (after EOP SE0) → `LINK_ACTIVE`.
    - SE0 ≥ `T_RESET_CYC` → `LINK_RESET`.
- `connect_req`=0 in any state → `LINK_DETACHED` next cycle. This takes priority over every other transition. Detach timer restarts from 0.
- `connect_req` re-asserting before `T_DETACH_CYC` elapses does not shorten the detach time.
- Strobes:
  - `ev_reset` pulses on every entry to `LINK_RESET`, including from `LINK_SUSPEND`/`LINK_RESUME`.
  - `ev_suspend` pulses on entry to `LINK_SUSPEND`.
  - `ev_resume` pulses on entry to `LINK_RESUME`.
  - No strobe on staying in a state.
- SE1 is never a valid condition. It counts toward no threshold.

## Timing
- Reset values:
  - `link_state`=`LINK_DETACHED`; `pullup_en`=0; `bus_reset`=0; `suspended`=0.
  - All strobes 0; `line_state`=`SE0`; timer 0.
- Reset mid-operation returns to `LINK_DETACHED` the next cycle, and the full detach time is re-enforced.
- Latency `d_i` → filtered `line_state`: 2 (synchronizer) + `T_DEBOUNCE_CYC` + 1 cycles.
- Thresholds are inclusive: the transition is registered on the cycle the timer equals the threshold. The state output follows one cycle later.
- All outputs are registered.
- Strobes coincide with the first cycle of the new `link_state`.

## Configuration
- `USB_REMOTE_WAKEUP_EN` defined:
  - Adds ports `wakeup_req` (in 1), `rw_d_o` (out `d_port_t`) and `rw_d_en` (out 1).
  - In `LINK_SUSPEND`, with `wakeup_req`=1 and the J timer ≥ `T_SUSPEND_CYC`+240000 (5 ms idle), the block drives K for 96000 cycles (2 ms) via `rw_d_en`=1.
  - It then releases the line and enters `LINK_RESUME`, pulsing `ev_resume`.
- `USB_REMOTE_WAKEUP_EN` undefined: those ports are absent and `wakeup_req` behaviour does not exist.
- Top level muxes `rw_d_*` with the SIE drivers.

## Structure
- Package `types` gains:
  - `line_state_t` (`SE0`, `J`, `K`, `SE1`).
  - `link_state_t` (6 states).
  - Default timing constants.
- `types` already holds `d_port_t` and `USB_FULL_SPEED`.
- One sub-module, `usb_line_filter`: synchronizer, J/K decode, debounce. It outputs filtered `line_state` and a one-cycle `changed` flag.
- FSM and timer live in `usb_link_ctrl`.

## Test plan
All scenarios use `T_DETACH_CYC`=50, `T_RESET_CYC`=12, `T_SUSPEND_CYC`=30, `T_DEBOUNCE_CYC`=4.
- **Attach:** release reset with `connect_req`=1 → `pullup_en` rises exactly 51 cycles later; `link_state`=`LINK_ATTACHED`.
- **Bus reset:** drive SE0 for 20 cycles in `LINK_ATTACHED`, then J → `ev_reset` single pulse; `bus_reset` high until filtered J; then `LINK_ACTIVE`.
- **Reset threshold edge:** SE0 lasting 11 filtered cycles → no transition. SE0 lasting 12 → `LINK_RESET`.
- **Suspend/resume:** J for 30 cycles → `ev_suspend`, `suspended`=1. Then K for 10 cycles, SE0 for 2, J → `ev_resume`, then `LINK_ACTIVE`.
- **Disconnect glitch:** drop `connect_req` for 3 cycles while in `LINK_ACTIVE` → `pullup_en`=0 the next cycle and stays 0 for 50 cycles; no `ev_*` strobes.
- **Transmit freeze:** hold J for 40 cycles with `d_en`=1 → no `LINK_SUSPEND`. Release `d_en` → suspend fires 30 cycles later.

Source files
------------

// File: rtl/usb_link_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_link_ctrl_pkg
// Description : Shared USB link-layer types: pin pair, line states, link FSM
//               states, default timing constants and the J/K line decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_link_ctrl_pkg;

  // Raw pin pair {D+, D-}
  typedef logic [1:0] d_port_t;

  // 1 = full-speed device (J is D+ high), 0 = low-speed (J is D- high)
  localparam bit USB_FULL_SPEED = 1'b1;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    LINK_DETACHED = 3'd0,
    LINK_ATTACHED = 3'd1,
    LINK_RESET    = 3'd2,
    LINK_ACTIVE   = 3'd3,
    LINK_SUSPEND  = 3'd4,
    LINK_RESUME   = 3'd5
  } link_state_t;

  // Default timing at 48 MHz
  localparam int DEF_T_DETACH_CYC   = 480000;  // 10 ms
  localparam int DEF_T_RESET_CYC    = 120;     // 2.5 us
  localparam int DEF_T_SUSPEND_CYC  = 144000;  // 3 ms
  localparam int DEF_T_DEBOUNCE_CYC = 4;
  localparam int DEF_CNT_W          = 20;

  // Remote wakeup: extra idle beyond suspend (5 ms total 8 ms) and K drive (2 ms)
  localparam int RW_IDLE_EXTRA_CYC  = 240000;
  localparam int RW_DRIVE_CYC       = 96000;

  // Decode a synchronized pin pair into a bus line state
  function automatic line_state_t decode_line(input d_port_t d);
    line_state_t ls;
    case (d)
      2'b00:   ls = SE0;
      2'b11:   ls = SE1;
      default: ls = ((USB_FULL_SPEED ? d[1] : d[0]) == 1'b1) ? J : K;
    endcase
    return ls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_link_ctrl_line.sv
`default_nettype none
// ============================================================================
// Module      : usb_line_filter
// Description : Two-flop synchronizer for D+/D-, J/K decode and a stability
//               filter. line_state moves only once the decoded value has been
//               steady for T_DEBOUNCE_CYC compares; changed pulses with it.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_line_filter
  import usb_link_ctrl_pkg::*;
#(
  parameter int T_DEBOUNCE_CYC = DEF_T_DEBOUNCE_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  d_port_t     d_i,
  output line_state_t line_state,
  output logic        changed
);

  localparam int                DB_W    = $clog2(T_DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0]   c_db_last = DB_W'(T_DEBOUNCE_CYC - 1);

  d_port_t         r_sync1;
  d_port_t         r_sync2;
  line_state_t     r_raw_q;
  logic [DB_W-1:0] r_cnt;
  line_state_t     w_raw;
  logic            w_stable;

  // Decode the synchronized pins and judge stability against the last sample
  always_comb begin
    w_raw    = decode_line(r_sync2);
    w_stable = (w_raw == r_raw_q) && (r_cnt >= c_db_last);
  end

  // Synchronize, count identical samples and commit the filtered line state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 2'b00;
      r_sync2    <= 2'b00;
      r_raw_q    <= SE0;
      r_cnt      <= '0;
      line_state <= SE0;
      changed    <= 1'b0;
    end else begin
      r_sync1 <= d_i;
      r_sync2 <= r_sync1;
      r_raw_q <= w_raw;
      if (w_raw != r_raw_q) begin
        r_cnt <= '0;
      end else if (r_cnt < c_db_last) begin
        r_cnt <= r_cnt + DB_W'(1);
      end
      changed <= 1'b0;
      if (w_stable && (w_raw != line_state)) begin
        line_state <= w_raw;
        changed    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_link_ctrl
// Description : USB device link sequencer: soft-connect pull-up, bus event
//               classification (attach, bus reset, suspend, resume) and
//               one-cycle event strobes. Optional remote wakeup is built when
//               USB_REMOTE_WAKEUP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_link_ctrl
  import usb_link_ctrl_pkg::*;
#(
  parameter int T_DETACH_CYC   = DEF_T_DETACH_CYC,
  parameter int T_RESET_CYC    = DEF_T_RESET_CYC,
  parameter int T_SUSPEND_CYC  = DEF_T_SUSPEND_CYC,
  parameter int T_DEBOUNCE_CYC = DEF_T_DEBOUNCE_CYC,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  d_port_t     d_i,
  input  logic        d_en,
  input  logic        connect_req,
`ifdef USB_REMOTE_WAKEUP_EN
  input  logic        wakeup_req,
  output d_port_t     rw_d_o,
  output logic        rw_d_en,
`endif
  output logic        pullup_en,
  output logic        bus_reset,
  output logic        suspended,
  output logic        ev_reset,
  output logic        ev_suspend,
  output logic        ev_resume,
  output line_state_t line_state,
  output link_state_t link_state
);

  localparam logic [CNT_W-1:0] c_max      = '1;
  localparam logic [CNT_W-1:0] c_t_detach = CNT_W'(T_DETACH_CYC);
  localparam logic [CNT_W-1:0] c_t_reset  = CNT_W'(T_RESET_CYC);
  localparam logic [CNT_W-1:0] c_t_susp   = CNT_W'(T_SUSPEND_CYC);

  logic             w_changed;
  link_state_t      r_state;
  link_state_t      w_next;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] w_run;
  logic [CNT_W-1:0] w_timer_nxt;
  logic             w_freeze;
  logic             w_se0_hit;
  logic             w_idle_hit;

  usb_line_filter #(
    .T_DEBOUNCE_CYC (T_DEBOUNCE_CYC)
  ) u_line_filter (
    .clk        (clk),
    .reset      (reset),
    .d_i        (d_i),
    .line_state (line_state),
    .changed    (w_changed)
  );

`ifdef USB_REMOTE_WAKEUP_EN
  localparam logic [CNT_W-1:0] c_rw_idle = CNT_W'(T_SUSPEND_CYC + RW_IDLE_EXTRA_CYC);
  localparam logic [CNT_W-1:0] c_rw_last = CNT_W'(RW_DRIVE_CYC - 1);
  localparam d_port_t          c_k_code  = USB_FULL_SPEED ? 2'b01 : 2'b10;

  logic             r_rw_active;
  logic [CNT_W-1:0] r_rw_cnt;
  logic             w_rw_start;

  assign rw_d_o   = c_k_code;
  assign rw_d_en  = r_rw_active;
  // Our own K drive must not be read back as bus activity
  assign w_freeze = d_en | r_rw_active;
`else
  assign w_freeze = d_en;
`endif

  // Running length of the current filtered line state, including this cycle
  always_comb begin
    w_inc = (r_timer == c_max) ? r_timer : r_timer + CNT_W'(1);
    if (r_state == LINK_DETACHED) begin
      w_run = r_timer;
    end else if (w_freeze) begin
      w_run = '0;
    end else if (w_changed) begin
      w_run = CNT_W'(1);
    end else begin
      w_run = w_inc;
    end
    w_se0_hit  = !w_freeze && (line_state == SE0) && (w_run >= c_t_reset);
    w_idle_hit = !w_freeze && (line_state == J)   && (w_run >= c_t_susp);
  end

  // Next link state; disconnect overrides every other transition
  always_comb begin
    w_next = r_state;
`ifdef USB_REMOTE_WAKEUP_EN
    w_rw_start = 1'b0;
`endif
    case (r_state)
      LINK_DETACHED: begin
        if (r_timer >= c_t_detach) w_next = LINK_ATTACHED;
      end
      LINK_ATTACHED: begin
        if (w_se0_hit) w_next = LINK_RESET;
      end
      LINK_RESET: begin
        if (!w_freeze && (line_state != SE0)) w_next = LINK_ACTIVE;
      end
      LINK_ACTIVE: begin
        if (w_se0_hit)       w_next = LINK_RESET;
        else if (w_idle_hit) w_next = LINK_SUSPEND;
      end
      LINK_SUSPEND: begin
`ifdef USB_REMOTE_WAKEUP_EN
        if (r_rw_active) begin
          if (r_rw_cnt == c_rw_last) w_next = LINK_RESUME;
        end else if (wakeup_req && (line_state == J) && (w_run >= c_rw_idle)) begin
          w_rw_start = 1'b1;
        end else
`endif
        if (!w_freeze && (line_state == K)) w_next = LINK_RESUME;
        else if (w_se0_hit)                 w_next = LINK_RESET;
      end
      LINK_RESUME: begin
        if (!w_freeze && (line_state == J)) w_next = LINK_ACTIVE;
        else if (w_se0_hit)                 w_next = LINK_RESET;
      end
      default: w_next = LINK_DETACHED;
    endcase
    if (!connect_req) w_next = LINK_DETACHED;

    // Timer restarts on entering or leaving DETACHED, else tracks the run
    if ((w_next != r_state) &&
        ((r_state == LINK_DETACHED) || (w_next == LINK_DETACHED))) begin
      w_timer_nxt = '0;
    end else if (r_state == LINK_DETACHED) begin
      w_timer_nxt = w_inc;
    end else begin
      w_timer_nxt = w_run;
    end
  end

  // State, timer and registered outputs; strobes mark the first cycle of a state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= LINK_DETACHED;
      r_timer    <= '0;
      pullup_en  <= 1'b0;
      bus_reset  <= 1'b0;
      suspended  <= 1'b0;
      ev_reset   <= 1'b0;
      ev_suspend <= 1'b0;
      ev_resume  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_timer    <= w_timer_nxt;
      pullup_en  <= (w_next != LINK_DETACHED);
      bus_reset  <= (w_next == LINK_RESET);
      suspended  <= (w_next == LINK_SUSPEND);
      ev_reset   <= (w_next == LINK_RESET)   && (r_state != LINK_RESET);
      ev_suspend <= (w_next == LINK_SUSPEND) && (r_state != LINK_SUSPEND);
      ev_resume  <= (w_next == LINK_RESUME)  && (r_state != LINK_RESUME);
    end
  end

`ifdef USB_REMOTE_WAKEUP_EN
  // Remote wakeup K drive: armed from suspend, dropped on leaving suspend
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rw_active <= 1'b0;
      r_rw_cnt    <= '0;
    end else begin
      if (w_next != LINK_SUSPEND) r_rw_active <= 1'b0;
      else if (w_rw_start)        r_rw_active <= 1'b1;
      r_rw_cnt <= r_rw_active ? r_rw_cnt + CNT_W'(1) : '0;
    end
  end
`endif

  assign link_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_usb_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_link_ctrl
// Description : Directed self-checking bench for usb_link_ctrl with short
//               timing (detach 50, reset 12, suspend 30, debounce 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_link_ctrl;
  import usb_link_ctrl_pkg::*;

  localparam d_port_t D_SE0 = 2'b00;
  localparam d_port_t D_J   = 2'b10;
  localparam d_port_t D_K   = 2'b01;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  d_port_t     d_i = D_SE0;
  logic        d_en = 1'b0;
  logic        connect_req = 1'b1;
  logic        pullup_en, bus_reset, suspended;
  logic        ev_reset, ev_suspend, ev_resume;
  line_state_t line_state;
  link_state_t link_state;
`ifdef USB_REMOTE_WAKEUP_EN
  logic        wakeup_req = 1'b0;
  d_port_t     rw_d_o;
  logic        rw_d_en;
`endif

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  usb_link_ctrl #(
    .T_DETACH_CYC   (50),
    .T_RESET_CYC    (12),
    .T_SUSPEND_CYC  (30),
    .T_DEBOUNCE_CYC (4),
    .CNT_W          (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d_i         (d_i),
    .d_en        (d_en),
    .connect_req (connect_req),
`ifdef USB_REMOTE_WAKEUP_EN
    .wakeup_req  (wakeup_req),
    .rw_d_o      (rw_d_o),
    .rw_d_en     (rw_d_en),
`endif
    .pullup_en   (pullup_en),
    .bus_reset   (bus_reset),
    .suspended   (suspended),
    .ev_reset    (ev_reset),
    .ev_suspend  (ev_suspend),
    .ev_resume   (ev_resume),
    .line_state  (line_state),
    .link_state  (link_state)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_link",    link_state, LINK_DETACHED);
    chk("rst_pullup",  pullup_en, 0);
    chk("rst_busrst",  bus_reset, 0);
    chk("rst_susp",    suspended, 0);
    chk("rst_strobes", {ev_reset, ev_suspend, ev_resume}, 0);
    chk("rst_line",    line_state, SE0);

    // Attach: pull-up rises 51 edges after reset release
    reset = 1'b0;
    d_i   = D_J;
    tick(50);
    chk("att_pre_pullup", pullup_en, 0);
    chk("att_pre_link",   link_state, LINK_DETACHED);
    tick(1);
    chk("att_pullup", pullup_en, 1);
    chk("att_link",   link_state, LINK_ATTACHED);
    chk("att_line",   line_state, J);

    // Bus reset: 20 cycles SE0 then J
    d_i = D_SE0;
    tick(18);
    chk("br_pre_link",  link_state, LINK_ATTACHED);
    chk("br_pre_ev",    ev_reset, 0);
    tick(1);
    chk("br_link",      link_state, LINK_RESET);
    chk("br_ev",        ev_reset, 1);
    chk("br_busrst",    bus_reset, 1);
    tick(1);
    chk("br_ev_single", ev_reset, 0);
    chk("br_hold",      bus_reset, 1);
    d_i = D_J;
    tick(7);
    chk("br_line_j",    line_state, J);
    chk("br_still",     bus_reset, 1);
    tick(1);
    chk("br_active",    link_state, LINK_ACTIVE);
    chk("br_release",   bus_reset, 0);

    // Threshold edge: 11 filtered SE0 cycles do nothing
    d_i = D_SE0;
    tick(11);
    d_i = D_J;
    tick(6);
    chk("th11_line",  line_state, SE0);
    chk("th11_link0", link_state, LINK_ACTIVE);
    tick(1);
    chk("th11_link1", link_state, LINK_ACTIVE);
    chk("th11_linej", line_state, J);

    // Threshold edge: 12 filtered SE0 cycles reset the bus
    d_i = D_SE0;
    tick(12);
    d_i = D_J;
    tick(6);
    chk("th12_pre",  link_state, LINK_ACTIVE);
    tick(1);
    chk("th12_link", link_state, LINK_RESET);
    chk("th12_ev",   ev_reset, 1);
    tick(1);
    chk("th12_back", link_state, LINK_ACTIVE);

    // Suspend after 30 idle J cycles
    tick(28);
    chk("sus_pre",     link_state, LINK_ACTIVE);
    chk("sus_pre_ev",  ev_suspend, 0);
    tick(1);
    chk("sus_link",    link_state, LINK_SUSPEND);
    chk("sus_ev",      ev_suspend, 1);
    chk("sus_flag",    suspended, 1);
    tick(1);
    chk("sus_ev_once", ev_suspend, 0);
    chk("sus_hold",    suspended, 1);

    // Resume: K 10, SE0 2 (filtered out), then J
    d_i = D_K;
    tick(7);
    chk("res_line_k",  line_state, K);
    chk("res_pre",     link_state, LINK_SUSPEND);
    tick(1);
    chk("res_link",    link_state, LINK_RESUME);
    chk("res_ev",      ev_resume, 1);
    chk("res_unsusp",  suspended, 0);
    tick(1);
    chk("res_ev_once", ev_resume, 0);
    tick(1);
    d_i = D_SE0;
    tick(2);
    d_i = D_J;
    tick(6);
    chk("res_glitch",  line_state, K);
    tick(1);
    chk("res_line_j",  line_state, J);
    chk("res_wait",    link_state, LINK_RESUME);
    tick(1);
    chk("res_active",  link_state, LINK_ACTIVE);

    // Disconnect glitch: 3 cycles low, pull-up off 51 cycles, no strobes
    connect_req = 1'b0;
    for (int i = 1; i <= 51; i++) begin
      tick(1);
      chk("dis_pullup",  pullup_en, 0);
      chk("dis_link",    link_state, LINK_DETACHED);
      chk("dis_strobes", {ev_reset, ev_suspend, ev_resume}, 0);
      if (i == 3) connect_req = 1'b1;
    end
    tick(1);
    chk("dis_reattach", pullup_en, 1);
    chk("dis_att_link", link_state, LINK_ATTACHED);

    // Bring the link to ACTIVE again
    d_i = D_SE0;
    tick(15);
    d_i = D_J;
    tick(4);
    chk("fr_reset",  link_state, LINK_RESET);
    tick(4);
    chk("fr_active", link_state, LINK_ACTIVE);

    // Transmit freeze: 40 cycles of J with d_en high, then suspend 30 later
    d_en = 1'b1;
    tick(40);
    chk("fr_frozen",   link_state, LINK_ACTIVE);
    d_en = 1'b0;
    tick(29);
    chk("fr_pre_sus",  link_state, LINK_ACTIVE);
    tick(1);
    chk("fr_suspend",  link_state, LINK_SUSPEND);
    chk("fr_ev",       ev_suspend, 1);

    // Reset mid-operation: back to DETACHED, full detach time again
    reset = 1'b1;
    tick(1);
    chk("mr_link",   link_state, LINK_DETACHED);
    chk("mr_pullup", pullup_en, 0);
    chk("mr_susp",   suspended, 0);
    chk("mr_line",   line_state, SE0);
    reset = 1'b0;
    tick(50);
    chk("mr_pre_pullup", pullup_en, 0);
    tick(1);
    chk("mr_pullup_up",  pullup_en, 1);
    chk("mr_att",        link_state, LINK_ATTACHED);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
